// File: rtl/seq_scan_controller_pkg.sv
// Shared constants for the "101" scan controller: default widths and FSM state codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package seq_pkg;

  // Default pattern width and match counter width
  localparam int N_DEF     = 10;
  localparam int CNT_W_DEF = 4;

  // FSM state codes, kept as plain constants so older code can compare raw values
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // A scan is in progress from the cycle after the start edge until the last match is in
  function automatic logic is_busy(input logic [2:0] s);
    return (s == S_LOAD) || (s == S_SHIFT) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/seq_scan_controller_rise_edge.sv
// Rising-edge detector for a debounced button level.
// Latency: rise is combinational from in_lvl against the previous-cycle sample.
// Backpressure: none; a level already high when reset releases is not reported as a press.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic in_lvl,
  output logic rise
);

  logic in_q, in_d;
  logic seen_low_q, seen_low_d;

  // Track the previous level and whether the button has been seen released since reset
  always_comb begin
    in_d       = in_lvl;
    seen_low_d = seen_low_q | ~in_lvl;
  end

  // Sample registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q       <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      in_q       <= in_d;
      seen_low_q <= seen_low_d;
    end
  end

  assign rise = in_lvl & ~in_q & seen_low_q;

endmodule

// File: rtl/seq_scan_controller.sv
// Snapshots a switch pattern on a start press and streams it LSB first to a "101" detector.
// Latency: det_clr 1 cycle after the press; first det_en 2 cycles later; done 2 cycles after last det_en.
// Backpressure: none; bits are paced by tick, presses during a scan are ignored, abort wins.
module seq_scan_controller
  import seq_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int IDX_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             tick,
  input  logic [N-1:0]     pattern,
  input  logic             det_match,
  output logic             det_clr,
  output logic             det_en,
  output logic             det_bit,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] bit_idx,
  output logic [CNT_W-1:0] match_count
);

  logic             start_edge;
  logic [2:0]       state_q, state_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic             det_clr_q, det_clr_d;
  logic             det_en_q, det_en_d;
  logic             det_bit_q, det_bit_d;

  rise_edge u_start_edge (
    .clk    (clk),
    .rst    (rst),
    .in_lvl (start),
    .rise   (start_edge)
  );

  // Next-state and datapath: start/snapshot, paced shifting, drain wait, match counting, abort
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    bit_idx_d     = bit_idx_q;
    match_count_d = match_count_q;
    det_clr_d     = 1'b0;
    det_en_d      = 1'b0;
    det_bit_d     = det_bit_q;

    // Matches only belong to the current scan once the detector has been cleared
    if ((state_q == S_SHIFT || state_q == S_DRAIN) && det_match &&
        (match_count_q != {CNT_W{1'b1}})) begin
      match_count_d = match_count_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_d       = S_LOAD;
          shadow_d      = pattern;
          bit_idx_d     = '0;
          match_count_d = '0;
          det_clr_d     = 1'b1;
        end
      end
      S_LOAD: begin
        // Detector clear is on the wire this cycle, so no bit may go out yet
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (tick) begin
          det_en_d  = 1'b1;
          det_bit_d = shadow_q[bit_idx_q];
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(N - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Stay while the last strobe is out; the following cycle carries its registered match
        if (!det_en_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d       = S_IDLE;
      bit_idx_d     = '0;
      match_count_d = '0;
      det_en_d      = 1'b0;
      det_clr_d     = 1'b0;
    end
  end

  // All controller state, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shadow_q      <= '0;
      bit_idx_q     <= '0;
      match_count_q <= '0;
      det_clr_q     <= 1'b0;
      det_en_q      <= 1'b0;
      det_bit_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      bit_idx_q     <= bit_idx_d;
      match_count_q <= match_count_d;
      det_clr_q     <= det_clr_d;
      det_en_q      <= det_en_d;
      det_bit_q     <= det_bit_d;
    end
  end

  assign det_clr     = det_clr_q;
  assign det_en      = det_en_q;
  assign det_bit     = det_bit_q;
  assign busy        = is_busy(state_q);
  assign done        = (state_q == S_DONE);
  assign bit_idx     = bit_idx_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_seq_scan_controller.sv
// Bench for seq_scan_controller: two instances (4-bit and 2-bit match counters) share stimulus.
// A behavioural "101" detector feeds det_match; a timestamp/counter model predicts every output.
module tb_seq_scan_controller;

  localparam int N = 10;
  localparam logic [9:0] P1 = 10'b1010010101;
  localparam logic [9:0] P3 = 10'b0101010101;

  logic       clk, rst, start, abort, tick, det_match;
  logic [9:0] pattern;
  logic       det_clr_a, det_en_a, det_bit_a, busy_a, done_a;
  logic [3:0] bit_idx_a;
  logic [3:0] match_count_a;
  logic       det_clr_b, det_en_b, det_bit_b, busy_b, done_b;
  logic [3:0] bit_idx_b;
  logic [1:0] match_count_b;

  int tests = 0;
  int fails = 0;
  int tick_mode = 0;
  int tick_ph = 0;
  int en_count = 0;
  int clr_count = 0;
  logic [15:0] seq;

  seq_scan_controller #(.N(10), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .tick(tick), .pattern(pattern),
    .det_match(det_match), .det_clr(det_clr_a), .det_en(det_en_a), .det_bit(det_bit_a),
    .busy(busy_a), .done(done_a), .bit_idx(bit_idx_a), .match_count(match_count_a)
  );

  seq_scan_controller #(.N(10), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .tick(tick), .pattern(pattern),
    .det_match(det_match), .det_clr(det_clr_b), .det_en(det_en_b), .det_bit(det_bit_b),
    .busy(busy_b), .done(done_b), .bit_idx(bit_idx_b), .match_count(match_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural overlapping "101" detector with a registered match output
  logic [1:0] hist;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 2'b00; det_match <= 1'b0;
    end else if (det_clr_a) begin
      hist <= 2'b00; det_match <= 1'b0;
    end else if (det_en_a) begin
      det_match <= ({hist, det_bit_a} == 3'b101);
      hist      <= {hist[0], det_bit_a};
    end else begin
      det_match <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  // Reference model: a scan is a stream of N shadow bits; a bit leaves on the cycle after a
  // tick once one clear cycle has passed; done follows two cycles after the last bit.
  bit         m_busy, m_done, m_en, m_clr, m_bit, m_low_before;
  int         m_age, m_sent, m_drain, m_cnt;
  logic [9:0] m_shadow;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_en = 0; m_clr = 0; m_bit = 0; m_low_before = 0;
    m_age = 0; m_sent = 0; m_drain = 0; m_cnt = 0; m_shadow = '0;
  endtask

  task automatic model_advance();
    bit press;
    press        = start && m_low_before;
    m_low_before = !start;
    m_en  = 0;
    m_clr = 0;
    if (abort) begin
      m_busy = 0; m_done = 0; m_sent = 0; m_cnt = 0;
    end else if (m_busy) begin
      if (m_age >= 1 && det_match) m_cnt++;
      if (m_sent < N) begin
        if (m_age >= 1 && tick) begin
          m_en = 1; m_bit = m_shadow[m_sent]; m_sent++; m_drain = 0;
        end
      end else if (m_drain == 0) begin
        m_drain = 1;
      end else begin
        m_busy = 0; m_done = 1;
      end
      m_age++;
    end else if (press) begin
      m_busy = 1; m_done = 0; m_age = 0; m_sent = 0; m_cnt = 0; m_clr = 1; m_shadow = pattern;
    end
  endtask

  // Compare process: every falling edge, check both instances against the model, then advance it
  always @(negedge clk) begin
    if (rst) model_reset();
    chk("det_clr_a", int'(det_clr_a), int'(m_clr));
    chk("det_en_a", int'(det_en_a), int'(m_en));
    chk("busy_a", int'(busy_a), int'(m_busy));
    chk("done_a", int'(done_a), int'(m_done));
    chk("bit_idx_a", int'(bit_idx_a), m_sent);
    chk("match_count_a", int'(match_count_a), sat(m_cnt, 4));
    chk("det_en_b", int'(det_en_b), int'(m_en));
    chk("det_clr_b", int'(det_clr_b), int'(m_clr));
    chk("busy_b", int'(busy_b), int'(m_busy));
    chk("done_b", int'(done_b), int'(m_done));
    chk("bit_idx_b", int'(bit_idx_b), m_sent);
    chk("match_count_b", int'(match_count_b), sat(m_cnt, 2));
    if (m_en) begin
      chk("det_bit_a", int'(det_bit_a), int'(m_bit));
      chk("det_bit_b", int'(det_bit_b), int'(m_bit));
    end
    if (det_en_a) begin
      if (en_count < 16) seq[en_count] = det_bit_a;
      en_count++;
    end
    if (det_clr_a) clr_count++;
    if (!rst) model_advance();
  end

  // Tick source: every 4 clk, continuous, or random
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      tick_ph++;
      case (tick_mode)
        0:       tick = (tick_ph % 4 == 0);
        1:       tick = 1'b1;
        default: tick = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  task automatic press();
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_capture();
    en_count = 0; clr_count = 0; seq = '0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_a !== 1'b1 && k < 500) begin @(posedge clk); #2; k++; end
    if (done_a !== 1'b1) chk("wait_done_timeout", int'(done_a), 1);
  endtask

  task automatic wait_idx(input int v);
    int k = 0;
    while (int'(bit_idx_a) != v && k < 300) begin @(posedge clk); #2; k++; end
    if (int'(bit_idx_a) != v) chk("wait_idx_timeout", int'(bit_idx_a), v);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit do_abort, ended;
    int ab_at, k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_det_bit", int'(det_bit_a), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T1: basic scan, ticks every 4 clk
    tick_mode = 0; pattern = P1; clear_capture();
    press();
    wait_done();
    chk("t1_seq", int'(seq[9:0]), int'(P1));
    chk("t1_count", int'(match_count_a), 3);
    chk("t1_model_count", m_cnt, 3);
    chk("t1_done", int'(done_a), 1);
    chk("t1_bit_idx", int'(bit_idx_a), 10);

    // T2: all ones and all zeros with continuous ticks
    tick_mode = 1; pattern = 10'h3FF; clear_capture();
    press();
    wait_done();
    chk("t2_ones_count", int'(match_count_a), 0);
    chk("t2_ones_en", en_count, 10);
    chk("t2_ones_clr", clr_count, 1);
    pattern = 10'h000; clear_capture();
    press();
    wait_done();
    chk("t2_zeros_count", int'(match_count_a), 0);
    chk("t2_zeros_en", en_count, 10);
    chk("t2_zeros_clr", clr_count, 1);

    // T3: four matches saturate the 2-bit counter
    tick_mode = 0; pattern = P3; clear_capture();
    press();
    wait_done();
    chk("t3_model_count", m_cnt, 4);
    chk("t3_count_w4", int'(match_count_a), 4);
    chk("t3_count_w2", int'(match_count_b), 3);

    // T4: restart press and pattern change mid-scan are ignored; next press uses new pattern
    pattern = P1; clear_capture();
    press();
    wait_idx(3);
    pattern = P3;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    chk("t4_seq", int'(seq[9:0]), int'(P1));
    chk("t4_count", int'(match_count_a), 3);
    chk("t4_clr_once", clr_count, 1);
    clear_capture();
    press();
    wait_done();
    chk("t4_rescan_seq", int'(seq[9:0]), int'(P3));
    chk("t4_rescan_w4", int'(match_count_a), 4);
    chk("t4_rescan_w2", int'(match_count_b), 3);

    // T5: abort coinciding with a tick at bit_idx=5
    pattern = P1; clear_capture();
    press();
    k = 0;
    while (!(bit_idx_a == 4'd5 && tick == 1'b1) && k < 300) begin @(posedge clk); #2; k++; end
    chk("t5_align_idx", int'(bit_idx_a), 5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_det_en", int'(det_en_a), 0);
    chk("t5_busy", int'(busy_a), 0);
    chk("t5_bit_idx", int'(bit_idx_a), 0);
    chk("t5_count", int'(match_count_a), 0);
    repeat (3) @(posedge clk);
    #1 chk("t5_en_total", en_count, 5);

    // T6: asynchronous reset mid-shift with start held high
    tick_mode = 0; pattern = P1; clear_capture();
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    wait_idx(3);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_busy", int'(busy_a), 0);
    chk("t6_bit_idx", int'(bit_idx_a), 0);
    chk("t6_count", int'(match_count_a), 0);
    chk("t6_det_en", int'(det_en_a), 0);
    chk("t6_det_bit", int'(det_bit_a), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_capture();
    repeat (30) @(posedge clk);
    #1;
    chk("t6_held_no_start", int'(busy_a), 0);
    chk("t6_held_no_en", en_count, 0);
    press();
    wait_done();
    chk("t6_fresh_count", int'(match_count_a), 3);

    // Random scans: random patterns, tick pacing, stray presses, pattern churn, occasional abort
    for (int it = 0; it < 30; it++) begin
      tick_mode = int'($urandom_range(0, 2));
      pattern   = 10'($urandom);
      do_abort  = ($urandom_range(0, 3) == 0);
      ab_at     = int'($urandom_range(1, 40));
      ended     = 0;
      press();
      for (int c = 0; c < 400; c++) begin
        @(posedge clk); #2;
        if (!busy_a) begin ended = 1; break; end
        if ($urandom_range(0, 9) == 0) pattern = 10'($urandom);
        if ($urandom_range(0, 15) == 0) start = ~start;
        abort = do_abort && (c == ab_at);
      end
      abort = 1'b0;
      start = 1'b0;
      if (!ended) chk("rand_scan_timeout", int'(busy_a), 0);
    end

    repeat (5) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
